// File: rtl/max7219_chain_pkg.sv
// rtl/max7219_chain_pkg.sv - Shared constants, FSM states and frame helper for the MAX7219 chain sequencer
package max7219_chain_pkg;

  // MAX7219 register addresses
  localparam logic [3:0] C_ADDR_NOOP         = 4'h0;
  localparam logic [3:0] C_ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] C_ADDR_DECODE       = 4'h9;
  localparam logic [3:0] C_ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] C_ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] C_ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] C_ADDR_DISPLAY_TEST = 4'hF;

  // Number of frame groups in the power-up configuration table
  localparam int C_INIT_GROUPS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_DONE
  } state_e;

  // A serial frame is {don't-care nibble, register address, register value}
  function automatic logic [15:0] build_frame(input logic [3:0] addr, input logic [7:0] value);
    return {4'h0, addr, value};
  endfunction

endpackage

// File: rtl/max7219_init_rom.sv
// rtl/max7219_init_rom.sv - Power-up configuration frame per init group index
module max7219_init_rom
  import max7219_chain_pkg::*;
#(
  parameter logic [3:0] G_INTENSITY   = 4'h8,
  parameter logic [2:0] G_SCAN_LIMIT  = 3'h7,
  parameter logic [7:0] G_DECODE_MODE = 8'h00
) (
  input  logic [2:0]  group_i,
  output logic [15:0] frame_o
);

  // Groups run display-test off, decode, intensity, scan limit, then leave shutdown last
  always_comb begin
    frame_o = build_frame(C_ADDR_NOOP, 8'h00);
    case (group_i)
      3'd0:    frame_o = build_frame(C_ADDR_DISPLAY_TEST, 8'h00);
      3'd1:    frame_o = build_frame(C_ADDR_DECODE, G_DECODE_MODE);
      3'd2:    frame_o = build_frame(C_ADDR_INTENSITY, {4'h0, G_INTENSITY});
      3'd3:    frame_o = build_frame(C_ADDR_SCAN_LIMIT, {5'h0, G_SCAN_LIMIT});
      3'd4:    frame_o = build_frame(C_ADDR_SHUTDOWN, 8'h01);
      default: frame_o = build_frame(C_ADDR_NOOP, 8'h00);
    endcase
  end

endmodule

// File: rtl/max7219_chain_sequencer.sv
// rtl/max7219_chain_sequencer.sv - Frame-group sequencer driving max7219_if for a MAX7219 daisy chain
module max7219_chain_sequencer
  import max7219_chain_pkg::*;
#(
  parameter int         G_NB_MATRIX   = 8,
  parameter logic [3:0] G_INTENSITY   = 4'h8,
  parameter logic [2:0] G_SCAN_LIMIT  = 3'h7,
  parameter logic [7:0] G_DECODE_MODE = 8'h00,
  localparam int        MW            = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init_start,
  input  logic          i_wr_req,
  input  logic [MW-1:0] i_wr_matrix,
  input  logic [2:0]    i_wr_digit,
  input  logic [7:0]    i_wr_data,
  output logic          o_wr_ack,
  output logic          o_busy,
  output logic          o_init_done,
  output logic          o_start,
  output logic          o_en_load,
  output logic [15:0]   o_data,
  input  logic          i_done
);

  localparam logic [MW-1:0] C_LAST_FRAME = MW'(G_NB_MATRIX - 1);
  localparam logic [2:0]    C_LAST_GROUP = 3'(C_INIT_GROUPS - 1);

  state_e        state_q, state_d;
  logic [MW-1:0] frame_q, frame_d;
  logic [2:0]    group_q, group_d;
  logic          init_mode_q, init_mode_d;
  logic          init_done_q, init_done_d;
  logic [MW-1:0] wr_matrix_q, wr_matrix_d;
  logic [2:0]    wr_digit_q, wr_digit_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic [15:0]   init_frame;
  logic [15:0]   write_frame;
  logic [MW-1:0] dev_idx;
  logic          frame_active;

  max7219_init_rom #(
    .G_INTENSITY   (G_INTENSITY),
    .G_SCAN_LIMIT  (G_SCAN_LIMIT),
    .G_DECODE_MODE (G_DECODE_MODE)
  ) u_init_rom (
    .group_i (group_q),
    .frame_o (init_frame)
  );

  // Frame k is shifted furthest, so it ends up in device N-1-k; out-of-range targets never match
  always_comb begin
    dev_idx     = C_LAST_FRAME - frame_q;
    write_frame = build_frame(C_ADDR_NOOP, 8'h00);
    if (dev_idx == wr_matrix_q) begin
      write_frame = build_frame({1'b0, wr_digit_q} + C_ADDR_DIGIT0, wr_data_q);
    end
  end

  assign frame_active = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
  assign o_data       = frame_active ? (init_mode_q ? init_frame : write_frame) : 16'h0000;
  assign o_en_load    = frame_active && (frame_q == C_LAST_FRAME);
  assign o_start      = (state_q == ST_START);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_wr_ack     = (state_q == ST_DONE) && !init_mode_q;
  assign o_init_done  = init_done_q;

  // State and latched-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      group_q     <= '0;
      init_mode_q <= 1'b0;
      init_done_q <= 1'b0;
      wr_matrix_q <= '0;
      wr_digit_q  <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      group_q     <= group_d;
      init_mode_q <= init_mode_d;
      init_done_q <= init_done_d;
      wr_matrix_q <= wr_matrix_d;
      wr_digit_q  <= wr_digit_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state: accept init or write, then walk frames within a group and groups within init
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    group_d     = group_q;
    init_mode_d = init_mode_q;
    init_done_d = init_done_q;
    wr_matrix_d = wr_matrix_q;
    wr_digit_d  = wr_digit_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_init_start) begin
          init_mode_d = 1'b1;
          init_done_d = 1'b0;
          frame_d     = '0;
          group_d     = '0;
          state_d     = ST_START;
        end else if (i_wr_req && init_done_q) begin
          init_mode_d = 1'b0;
          wr_matrix_d = i_wr_matrix;
          wr_digit_d  = i_wr_digit;
          wr_data_d   = i_wr_data;
          frame_d     = '0;
          group_d     = '0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (frame_q != C_LAST_FRAME) begin
          frame_d = frame_q + 1'b1;
          state_d = ST_START;
        end else begin
          frame_d = '0;
          if (init_mode_q && (group_q != C_LAST_GROUP)) begin
            group_d = group_q + 3'd1;
            state_d = ST_START;
          end else begin
            if (init_mode_q) begin
              init_done_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
